mem_array_emu: RTL and testbench
================================

// Module: mem_array_emu
// PURPOSE
//  Chip-side responder for the accelerator pin interface: FPGA-synthesizable emulator of the memristor array ASIC.
//  Consumes CBL/CBLEN/CSL/CWL, mode pins and 8b row/col addresses; drives the 4b bit_out bus back to pinaipple_system.
//  Used in place of the ASIC for FPGA bring-up and as the closed-loop model in system sims.
// PARAMETERS
//  RowW       6   row address bits used (addr_row_i[RowW-1:0]); 2**RowW rows
//  ColW       6   nibble-column address bits used (addr_col_i[ColW-1:0]); each entry is 4b
//  ProgCycles 4   consecutive qualifying cycles needed to commit one program pulse (>=1)
//  ReadLat    2   cycles from read start to first valid nibble on bit_out_o (>=1)
// PORTS
//  clk_sys_in   in   1  system clock (same domain as the driving system; pins synchronous)
//  rst_sys_in   in   1  asynchronous reset, active-high
//  cbl_i        in   1  bitline level during program: 1=SET
//  cblen_i      in   1  bitline enable, qualifies a program pulse
//  csl_i        in   1  source line level during program: 1=RESET
//  cwl_i        in   1  wordline, program pulse active while high
//  inference_i  in   1  read mode select (see BEHAVIOUR)
//  read_8_i     in   1  with read start: two-beat 8b read
//  load_mem_i   in   1  rising edge starts array clear
//  read_out_i   in   1  rising edge starts a read
//  stoch_log_i  in   1  stochastic read enable (feature-gated)
//  addr_col_i   in   8  column address
//  addr_row_i   in   8  row address
//  bit_out_o    out  4  read data
//  busy_o       out  1  FSM not IDLE
//  err_o        out  1  sticky: illegal program (cbl_i & csl_i) or start while busy
// BEHAVIOUR
//  Reset: bit_out_o=0, busy_o=0, err_o=0, FSM=IDLE, prog counter=0, array contents undefined (load_mem clears).
//  FSM states: IDLE, PROG, RD_WAIT, RD_LO, RD_HI, LOAD.
//  IDLE->PROG: cwl_i & cblen_i. PROG counts cycles while cwl_i & cblen_i and row/col unchanged from entry.
//   Counter reaching ProgCycles: bit[col][0] of nibble at (row,col)... nibble lane = addr_col_i[ColW+1:ColW];
//   SET if cbl_i&~csl_i (lane<=1), RESET if csl_i&~cbl_i (lane<=0); cbl_i&csl_i: no write, err_o<=1.
//   Pulse dropped or address changed before count: abort, no write, back to IDLE (no error).
//   After commit stay in PROG until cwl_i low (one write per pulse), then IDLE.
//  IDLE->RD_WAIT: read_out_i rising edge (edge-detect register). Address and read_8_i latched at start.
//   RD_WAIT lasts ReadLat-1 cycles; RD_LO: bit_out_o=array[row][col] for 1 cycle.
//   read_8_i latched: RD_HI next cycle, bit_out_o=array[row][col^1] (column wrap within row via XOR of LSB).
//   Then IDLE; bit_out_o holds last value until next read. Total latency first nibble = ReadLat cycles.
//  inference_i latched at read start: output is bitwise OR of the nibble with nibble at col+1 (wraps to col 0 at top).
//  IDLE->LOAD: load_mem_i rising edge; clears one row per cycle, 2**RowW cycles, then IDLE. Reads during: none.
//  Any start event (cwl, read_out edge, load edge) while not IDLE: ignored, err_o<=1. Simultaneous starts in IDLE:
//   priority LOAD > PROG > READ; losers ignored, err_o<=1.
//  Reset mid-operation: FSM to IDLE immediately; partially committed program never written; LOAD abandoned.
//  err_o clears only on reset.
// CONFIGURATION
//  MEM_ARRAY_EMU_STOCH_EN defined: 16b Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) steps each cycle;
//   when stoch_log_i latched at read start, each output bit is XORed with (lfsr[3:0]==0) per lane-shifted draw (~1/16 flip).
//  Undefined: stoch_log_i ignored, reads deterministic, no LFSR logic.
// STRUCTURE
//  Package mem_array_emu_pkg: state enum, ProgCycles/ReadLat defaults, LFSR seed/taps constants.
//  Sub-module mem_array_emu_lfsr (only instantiated under MEM_ARRAY_EMU_STOCH_EN). Array as 2-D logic, no RAM macro.
// TESTING
//  Reset then load_mem pulse -> busy_o high 64 cycles, all reads return 4'h0.
//  Program (row 5,col 3,lane 2) SET, cwl held 4 cycles -> read_out edge -> after 2 cycles bit_out_o=4'b0100.
//  Same with cwl dropped after 3 cycles -> read returns 4'h0, err_o stays 0.
//  cbl_i=csl_i=1 program pulse -> no write, err_o=1.
//  read_8_i with col 3 holding 4'hA, col 2 holding 4'h5 -> bit_out_o 4'hA then 4'h5 on consecutive cycles.
//  rst_sys_in mid-PROG at count 3 -> busy_o=0 next edge, target nibble unchanged; read_out during LOAD -> err_o=1.

Source files
------------

// File: rtl/mem_array_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_array_emu_pkg
//  Brief   : Shared types and defaults for the memristor array emulator.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_array_emu_pkg;

    localparam int ROW_W_DEF       = 6;
    localparam int COL_W_DEF       = 6;
    localparam int PROG_CYCLES_DEF = 4;
    localparam int READ_LAT_DEF    = 2;

    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROG    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_LO   = 3'd3,
        ST_RD_HI   = 3'd4,
        ST_LOAD    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array_emu_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_array_emu_if
//  Brief   : Accelerator pin bundle between the system and the array emulator.
//  Rev     : 1.0  initial release
// ============================================================================
interface mem_array_emu_if;

    logic       cbl_i;
    logic       cblen_i;
    logic       csl_i;
    logic       cwl_i;
    logic       inference_i;
    logic       read_8_i;
    logic       load_mem_i;
    logic       read_out_i;
    logic       stoch_log_i;
    logic [7:0] addr_col_i;
    logic [7:0] addr_row_i;
    logic [3:0] bit_out_o;
    logic       busy_o;
    logic       err_o;

    modport master (
        output cbl_i, cblen_i, csl_i, cwl_i, inference_i, read_8_i,
               load_mem_i, read_out_i, stoch_log_i, addr_col_i, addr_row_i,
        input  bit_out_o, busy_o, err_o
    );

    modport slave (
        input  cbl_i, cblen_i, csl_i, cwl_i, inference_i, read_8_i,
               load_mem_i, read_out_i, stoch_log_i, addr_col_i, addr_row_i,
        output bit_out_o, busy_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_array_emu_lfsr.sv
`default_nettype none
// ============================================================================
//  Module  : mem_array_emu_lfsr
//  Brief   : Free-running 16b Fibonacci LFSR for stochastic read flips.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_array_emu_lfsr
    import mem_array_emu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_array_emu.sv
`default_nettype none
// ============================================================================
//  Module  : mem_array_emu
//  Brief   : Pin-level emulator of the memristor array ASIC (program, read,
//            clear). Optional stochastic reads under MEM_ARRAY_EMU_STOCH_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_array_emu
    import mem_array_emu_pkg::*;
#(
    parameter int ROW_W       = ROW_W_DEF,
    parameter int COL_W       = COL_W_DEF,
    parameter int PROG_CYCLES = PROG_CYCLES_DEF,
    parameter int READ_LAT    = READ_LAT_DEF
) (
    input  logic           clk_sys_in,
    input  logic           rst_sys_in,
    mem_array_emu_if.slave pins
);

    localparam int ROWS = 1 << ROW_W;
    localparam int COLS = 1 << COL_W;

    logic [3:0]       mem [ROWS][COLS];

    state_t           state, state_nx;
    logic [7:0]       cnt, cnt_nx;
    logic             done, done_nx;
    logic [7:0]       row_q, col_q;
    logic             rd8_q, inf_q;
    logic [ROW_W-1:0] load_row;
    logic             read_prev, load_prev;
    logic             err;
    logic [3:0]       bit_out;

    logic             prog_req, rd_edge, ld_edge, addr_same;
    logic             latch_prog, latch_rd, commit, set_err;
    logic             out_load, beat_hi, clear_row, wr_en;

    logic [ROW_W-1:0] prog_row, rd_row;
    logic [COL_W-1:0] prog_col, rd_base_col, rd_col, rd_col_nx;
    logic [1:0]       prog_lane;
    logic             rd_inf;
    logic [3:0]       rd_nib_raw, rd_nib;

    assign prog_req  = pins.cwl_i & pins.cblen_i;
    assign rd_edge   = pins.read_out_i & ~read_prev;
    assign ld_edge   = pins.load_mem_i & ~load_prev;
    assign addr_same = (pins.addr_row_i == row_q) && (pins.addr_col_i == col_q);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        done_nx    = done;
        latch_prog = 1'b0;
        latch_rd   = 1'b0;
        commit     = 1'b0;
        set_err    = 1'b0;
        out_load   = 1'b0;
        beat_hi    = 1'b0;
        clear_row  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld_edge) begin
                    state_nx = ST_LOAD;
                    set_err  = prog_req | rd_edge;
                end else if (prog_req) begin
                    state_nx   = ST_PROG;
                    latch_prog = 1'b1;
                    cnt_nx     = 8'd1;
                    commit     = (PROG_CYCLES == 1);
                    done_nx    = (PROG_CYCLES == 1);
                    set_err    = rd_edge;
                end else if (rd_edge) begin
                    latch_rd = 1'b1;
                    cnt_nx   = 8'd0;
                    if (READ_LAT == 1) begin
                        state_nx = ST_RD_LO;
                        out_load = 1'b1;
                    end else begin
                        state_nx = ST_RD_WAIT;
                    end
                end
            end
            ST_PROG: begin
                set_err = rd_edge | ld_edge;
                if (done) begin
                    // one write per pulse: wait here for the wordline to fall
                    if (!pins.cwl_i) state_nx = ST_IDLE;
                end else if (!prog_req || !addr_same) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                    if (cnt_nx == 8'(PROG_CYCLES)) begin
                        commit  = 1'b1;
                        done_nx = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                set_err = prog_req | rd_edge | ld_edge;
                if (cnt == 8'(READ_LAT - 2)) begin
                    state_nx = ST_RD_LO;
                    out_load = 1'b1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            ST_RD_LO: begin
                set_err = prog_req | rd_edge | ld_edge;
                if (rd8_q) begin
                    state_nx = ST_RD_HI;
                    out_load = 1'b1;
                    beat_hi  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RD_HI: begin
                set_err  = prog_req | rd_edge | ld_edge;
                state_nx = ST_IDLE;
            end
            ST_LOAD: begin
                set_err   = prog_req | rd_edge | ld_edge;
                clear_row = 1'b1;
                if (load_row == ROW_W'(ROWS - 1)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (commit && pins.cbl_i && pins.csl_i) set_err = 1'b1;
    end

    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            done      <= 1'b0;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            rd8_q     <= 1'b0;
            inf_q     <= 1'b0;
            load_row  <= '0;
            read_prev <= 1'b0;
            load_prev <= 1'b0;
            err       <= 1'b0;
            bit_out   <= 4'h0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            done      <= done_nx;
            read_prev <= pins.read_out_i;
            load_prev <= pins.load_mem_i;
            if (latch_prog || latch_rd) begin
                row_q <= pins.addr_row_i;
                col_q <= pins.addr_col_i;
            end
            if (latch_rd) begin
                rd8_q <= pins.read_8_i;
                inf_q <= pins.inference_i;
            end
            if (state == ST_IDLE) begin
                load_row <= '0;
            end else if (clear_row) begin
                load_row <= load_row + 1'b1;
            end
            if (set_err) err <= 1'b1;
            if (out_load) bit_out <= rd_nib;
        end
    end

    // Program uses live pins; they equal the latched address whenever commit fires.
    assign prog_row  = pins.addr_row_i[ROW_W-1:0];
    assign prog_col  = pins.addr_col_i[COL_W-1:0];
    assign prog_lane = pins.addr_col_i[COL_W+1:COL_W];
    assign wr_en     = commit & (pins.cbl_i ^ pins.csl_i) & ~rst_sys_in;

    always_ff @(posedge clk_sys_in) begin
        if (clear_row && !rst_sys_in) begin
            for (int c = 0; c < COLS; c++) begin
                mem[load_row][c[COL_W-1:0]] <= 4'h0;
            end
        end else if (wr_en) begin
            mem[prog_row][prog_col][prog_lane] <= pins.cbl_i;
        end
    end

    // With a one-cycle latency the first beat is fetched straight from the pins.
    assign rd_row      = (state == ST_IDLE) ? pins.addr_row_i[ROW_W-1:0] : row_q[ROW_W-1:0];
    assign rd_base_col = (state == ST_IDLE) ? pins.addr_col_i[COL_W-1:0] : col_q[COL_W-1:0];
    assign rd_inf      = (state == ST_IDLE) ? pins.inference_i : inf_q;
    assign rd_col      = rd_base_col ^ {{(COL_W-1){1'b0}}, beat_hi};
    assign rd_col_nx   = rd_col + 1'b1;
    assign rd_nib_raw  = mem[rd_row][rd_col] | (rd_inf ? mem[rd_row][rd_col_nx] : 4'h0);

`ifdef MEM_ARRAY_EMU_STOCH_EN
    logic [15:0] lfsr;
    logic        stoch_q;
    logic        rd_stoch;
    logic [3:0]  flip;

    mem_array_emu_lfsr u_lfsr (
        .clk  (clk_sys_in),
        .rst  (rst_sys_in),
        .lfsr (lfsr)
    );

    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            stoch_q <= 1'b0;
        end else if (latch_rd) begin
            stoch_q <= pins.stoch_log_i;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_flip
        assign flip[k] = (lfsr[4*k +: 4] == 4'h0);
    end

    assign rd_stoch = (state == ST_IDLE) ? pins.stoch_log_i : stoch_q;
    assign rd_nib   = rd_nib_raw ^ (rd_stoch ? flip : 4'h0);
`else
    assign rd_nib   = rd_nib_raw;
`endif

    assign pins.bit_out_o = bit_out;
    assign pins.busy_o    = (state != ST_IDLE);
    assign pins.err_o     = err;

endmodule
`default_nettype wire

// File: tb/tb_mem_array_emu.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_array_emu
//  Brief   : Random + directed bench with a transaction-level array model.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_array_emu;

    localparam int PROG_CYC = 4;
    localparam int RD_LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_array_emu_if pins();

    mem_array_emu dut (
        .clk_sys_in (clk),
        .rst_sys_in (rst),
        .pins       (pins)
    );

    logic [3:0] mdl [64][64];
    logic       exp_busy, exp_err;
    logic [3:0] exp_out;
    int         vectors     = 0;
    int         miscompares = 0;
    bit         chk_en      = 1'b0;
    logic [5:0] cols6 [6]   = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd62, 6'd63};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {7'd0, pins.busy_o}, {7'd0, exp_busy});
            check("err", {7'd0, pins.err_o}, {7'd0, exp_err});
            check("bit_out", {4'd0, pins.bit_out_o}, {4'd0, exp_out});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib(input int r, input int c, input bit inf);
        return mdl[r][c] | (inf ? mdl[r][(c + 1) % 64] : 4'h0);
    endfunction

    task automatic quiet();
        pins.cbl_i = 0; pins.cblen_i = 0; pins.csl_i = 0; pins.cwl_i = 0;
        pins.inference_i = 0; pins.read_8_i = 0; pins.load_mem_i = 0;
        pins.read_out_i = 0; pins.stoch_log_i = 0;
    endtask

    task automatic do_load(input bit with_read, input int read_at, output int busy_cnt);
        busy_cnt = 0;
        pins.load_mem_i = 1'b1;
        pins.read_out_i = with_read;
        step();
        pins.load_mem_i = 1'b0;
        pins.read_out_i = 1'b0;
        exp_busy = 1'b1;
        if (with_read) exp_err = 1'b1;
        busy_cnt += int'(pins.busy_o);
        for (int r = 0; r < 64; r++) for (int c = 0; c < 64; c++) mdl[r][c] = 4'h0;
        for (int i = 2; i <= 65; i++) begin
            pins.read_out_i = (i == read_at);
            step();
            if (i == read_at) exp_err = 1'b1;
            if (i == 65) exp_busy = 1'b0;
            busy_cnt += int'(pins.busy_o);
        end
        pins.read_out_i = 1'b0;
    endtask

    task automatic do_prog(input logic [7:0] row, input logic [7:0] col,
                           input bit cbl, input bit csl, input int hold);
        pins.addr_row_i = row; pins.addr_col_i = col;
        pins.cbl_i = cbl; pins.csl_i = csl; pins.cblen_i = 1'b1; pins.cwl_i = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            step();
            exp_busy = 1'b1;
            if (i == PROG_CYC) begin
                if (cbl && csl) exp_err = 1'b1;
                else if (cbl)   mdl[row[5:0]][col[5:0]][col[7:6]] = 1'b1;
                else if (csl)   mdl[row[5:0]][col[5:0]][col[7:6]] = 1'b0;
            end
        end
        pins.cwl_i = 1'b0; pins.cblen_i = 1'b0;
        step();
        exp_busy = 1'b0;
        pins.cbl_i = 1'b0; pins.csl_i = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] row, input logic [7:0] col, input bit rd8,
                           input bit inf, output logic [3:0] got0, output logic [3:0] got1);
        int r, c;
        r = int'(row[5:0]);
        c = int'(col[5:0]);
        pins.addr_row_i = row; pins.addr_col_i = col; pins.read_8_i = rd8;
        pins.inference_i = inf; pins.stoch_log_i = 1'($urandom); pins.read_out_i = 1'b1;
        step();
        exp_busy = 1'b1;
        // scramble pins: the read must use the values latched at start
        pins.read_out_i = 1'b0;
        pins.addr_row_i = 8'($urandom); pins.addr_col_i = 8'($urandom);
        pins.read_8_i = 1'($urandom); pins.inference_i = 1'($urandom);
        repeat (RD_LAT - 1) step();
        exp_out = nib(r, c, inf);
        got0 = pins.bit_out_o;
        got1 = got0;
        if (rd8) begin
            step();
            exp_out = nib(r, c ^ 1, inf);
            got1 = pins.bit_out_o;
        end
        step();
        exp_busy = 1'b0;
        quiet();
    endtask

    initial begin
        int         bc, kind;
        logic [3:0] g0, g1;
        logic [7:0] row, col;
        quiet();
        pins.addr_row_i = 8'd0; pins.addr_col_i = 8'd0;
        exp_busy = 1'b0; exp_err = 1'b0; exp_out = 4'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {7'd0, pins.busy_o}, 8'd0);
        check("reset_err", {7'd0, pins.err_o}, 8'd0);
        check("reset_bit_out", {4'd0, pins.bit_out_o}, 8'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        do_load(1'b0, 0, bc);
        check("load_busy_cycles", 8'(bc), 8'd64);
        do_read(8'd5, 8'd3, 1'b0, 1'b0, g0, g1);
        check("read_after_load", {4'd0, g0}, 8'h00);

        do_prog(8'd5, {2'd2, 6'd3}, 1'b1, 1'b0, 4);
        do_read(8'd5, 8'd3, 1'b0, 1'b0, g0, g1);
        check("prog_set_lane2", {4'd0, g0}, 8'h04);

        do_prog(8'd6, {2'd2, 6'd3}, 1'b1, 1'b0, 3);
        do_read(8'd6, 8'd3, 1'b0, 1'b0, g0, g1);
        check("short_pulse_no_write", {4'd0, g0}, 8'h00);
        check("short_pulse_no_err", {7'd0, pins.err_o}, 8'd0);

        do_prog(8'd7, {2'd1, 6'd3}, 1'b1, 1'b0, 4);
        do_prog(8'd7, {2'd3, 6'd3}, 1'b1, 1'b0, 5);
        do_prog(8'd7, {2'd0, 6'd2}, 1'b1, 1'b0, 4);
        do_prog(8'd7, {2'd2, 6'd2}, 1'b1, 1'b0, 6);
        do_read(8'd7, 8'd3, 1'b1, 1'b0, g0, g1);
        check("read8_beat0", {4'd0, g0}, 8'h0A);
        check("read8_beat1", {4'd0, g1}, 8'h05);
        do_read(8'd7, 8'd2, 1'b0, 1'b1, g0, g1);
        check("inference_or", {4'd0, g0}, 8'h0F);
        do_prog(8'd9, {2'd0, 6'd0}, 1'b1, 1'b0, 4);
        do_read(8'd9, 8'd63, 1'b0, 1'b1, g0, g1);
        check("inference_wrap", {4'd0, g0}, 8'h01);

        // address moves mid-pulse: abort, then the still-high pulse re-enters briefly
        pins.addr_row_i = 8'd8; pins.addr_col_i = 8'd3;
        pins.cbl_i = 1'b1; pins.cblen_i = 1'b1; pins.cwl_i = 1'b1;
        step(); exp_busy = 1'b1;
        step();
        pins.addr_col_i = 8'd4;
        step(); exp_busy = 1'b0;
        step(); exp_busy = 1'b1;
        quiet();
        step(); exp_busy = 1'b0;
        do_read(8'd8, 8'd3, 1'b1, 1'b0, g0, g1);
        check("addr_change_no_write", {g0, g1}, 8'h00);

        for (int t = 0; t < 250; t++) begin
            kind = int'($urandom_range(0, 99));
            row  = 8'($urandom) & 8'hC3;
            col  = {2'($urandom), cols6[$urandom_range(0, 5)]};
            if (kind < 5) begin
                do_load(1'b0, 0, bc);
            end else if (kind < 50) begin
                case ($urandom_range(0, 2))
                    0:       do_prog(row, col, 1'b1, 1'b0, int'($urandom_range(1, 7)));
                    1:       do_prog(row, col, 1'b0, 1'b1, int'($urandom_range(1, 7)));
                    default: do_prog(row, col, 1'b0, 1'b0, int'($urandom_range(1, 7)));
                endcase
            end else begin
                do_read(row, col, 1'($urandom), 1'($urandom), g0, g1);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        do_prog(8'd7, {2'd0, 6'd3}, 1'b1, 1'b1, 4);
        check("illegal_prog_err", {7'd0, pins.err_o}, 8'd1);
        do_load(1'b0, 0, bc);
        do_prog(8'd7, {2'd0, 6'd3}, 1'b1, 1'b0, 4);

        rst = 1'b1;
        exp_busy = 1'b0; exp_err = 1'b0; exp_out = 4'h0;
        step();
        rst = 1'b0;
        check("err_cleared_by_reset", {7'd0, pins.err_o}, 8'd0);

        // reset lands with the program counter at 3 on row 7 col 3 lane 1
        pins.addr_row_i = 8'd7; pins.addr_col_i = {2'd1, 6'd3};
        pins.cbl_i = 1'b1; pins.cblen_i = 1'b1; pins.cwl_i = 1'b1;
        repeat (3) begin
            step();
            exp_busy = 1'b1;
        end
        rst = 1'b1;
        exp_busy = 1'b0;
        #1;
        check("mid_prog_reset_busy", {7'd0, pins.busy_o}, 8'd0);
        quiet();
        step();
        rst = 1'b0;
        do_read(8'd7, 8'd3, 1'b0, 1'b0, g0, g1);
        check("mid_prog_reset_nibble", {4'd0, g0}, 8'h01);

        do_load(1'b0, 10, bc);
        check("read_during_load_err", {7'd0, pins.err_o}, 8'd1);

        rst = 1'b1;
        exp_err = 1'b0; exp_out = 4'h0;
        step();
        rst = 1'b0;
        do_prog(8'd7, {2'd2, 6'd3}, 1'b1, 1'b0, 4);
        do_load(1'b1, 0, bc);
        check("simul_start_err", {7'd0, pins.err_o}, 8'd1);
        do_read(8'd7, 8'd3, 1'b0, 1'b0, g0, g1);
        check("simul_start_load_wins", {4'd0, g0}, 8'h00);

        repeat (2) step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
